// File: rtl/conv_accum_stream.sv
// ---------------------------------------------------------------------------
// conv_accum_stream
//
// Multi-lane partial-sum accumulator that sits behind the convolution array.
// Each accepted beat carries NumCh signed conv results. The beat is parked in
// a small FIFO while the matching psum word is fetched from SRAM through an
// arbitrated read port. When the read data returns, the FIFO head is added
// lane by lane with saturation, and the result is written back to the same
// address. A pass processes `length` beats starting at `base_addr`.
//
// On a first pass (pass_first=1) no reads are issued. The conv results are
// written through unchanged, because the addend is zero.
//
// Optional feature macro: CONV_ACCUM_RELU_EN
//   When defined, a pass started with pass_last=1 writes any lane that is
//   negative after saturation as zero. err_sat still reports the clamp.
//   When undefined, pass_last is ignored and raw saturated sums are written.
//
// Ports
//   Clk, Rst          clock (rising edge) and synchronous active-low reset
//   start             begin a pass; only sampled while idle
//   base_addr, length first psum word address and beat count of the pass
//   pass_first        skip the psum read and write conv results directly
//   pass_last         final pass of the tile (ReLU when the macro is defined)
//   busy, done        pass in progress / one-cycle completion pulse
//   err_sat           sticky per pass: some lane saturated
//   in_data/valid/ready  conv result stream, lane k at [k*DataWidth +: DataWidth]
//   rd_en/gnt/addr/data  psum read port; data arrives RdLatency cycles after grant
//   wr_en/addr/data      psum write port (registered)
// ---------------------------------------------------------------------------
module conv_accum_stream #(
    parameter int DataWidth = 32,
    parameter int NumCh     = 4,
    parameter int AddrWidth = 16,
    parameter int RdLatency = 2,
    parameter int FifoDepth = 8
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       start,
    input  logic [AddrWidth-1:0]       base_addr,
    input  logic [AddrWidth-1:0]       length,
    input  logic                       pass_first,
    input  logic                       pass_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err_sat,
    input  logic [NumCh*DataWidth-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       rd_en,
    input  logic                       rd_gnt,
    output logic [AddrWidth-1:0]       rd_addr,
    input  logic [NumCh*DataWidth-1:0] rd_data,
    output logic                       wr_en,
    output logic [AddrWidth-1:0]       wr_addr,
    output logic [NumCh*DataWidth-1:0] wr_data
);

    localparam int BeatW = NumCh * DataWidth;
    localparam int PtrW  = $clog2(FifoDepth);
    localparam int CntW  = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [AddrWidth-1:0] base_q;
    logic [AddrWidth-1:0] len_q;
    logic                 first_q;
    logic                 last_q;
    logic [AddrWidth-1:0] acc_cnt;
    logic [AddrWidth-1:0] iss_cnt;
    logic [AddrWidth-1:0] wr_cnt;
    logic                 err_sat_q;

    logic [BeatW-1:0]     fifo_mem [FifoDepth];
    logic [PtrW-1:0]      fifo_wr_ptr;
    logic [PtrW-1:0]      fifo_rd_ptr;
    logic [CntW-1:0]      fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;

    logic [RdLatency-1:0] vld_sr;

    logic                 start_accept;
    logic                 push;
    logic                 pop;
    logic                 grant;

    logic [BeatW-1:0]     head_word;
    logic [BeatW-1:0]     addend;
    logic [BeatW-1:0]     sum_word;
    logic [NumCh-1:0]     lane_sat;
    logic [DataWidth-1:0] lane_a;
    logic [DataWidth-1:0] lane_b;
    logic [DataWidth:0]   lane_sum;
    logic [DataWidth-1:0] lane_res;

    // The full/empty flags come from the registered occupancy count. This
    // keeps rd_gnt from reaching in_ready through a combinational path.
    assign fifo_full  = (fifo_cnt == CntW'(FifoDepth));
    assign fifo_empty = (fifo_cnt == '0);

    assign push  = in_valid && in_ready;
    assign grant = rd_en && rd_gnt;

    // On a first pass the head drains as soon as it is present. Otherwise
    // the head waits for the matching read data at the end of the shift chain.
    assign pop = (state == RUN) && (first_q ? !fifo_empty : vld_sr[RdLatency-1]);

    assign head_word = fifo_mem[fifo_rd_ptr];
    assign addend    = first_q ? '0 : rd_data;
    assign rd_addr   = base_q + iss_cnt;
    assign err_sat   = err_sat_q;

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. A read is requested only for beats
    // that are already in the FIFO. This bounds the reads in flight to the
    // FIFO depth.
    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        in_ready     = 1'b0;
        rd_en        = 1'b0;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !fifo_full && (acc_cnt < len_q);
                rd_en    = !first_q && (iss_cnt < acc_cnt);
                if (wr_cnt == len_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pass configuration, beat counters and the sticky saturation flag.
    // wr_cnt advances at the pop, so it reaches len_q in the same cycle
    // that the final registered write is presented.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            base_q    <= '0;
            len_q     <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            acc_cnt   <= '0;
            iss_cnt   <= '0;
            wr_cnt    <= '0;
            err_sat_q <= 1'b0;
        end else if (start_accept) begin
            base_q    <= base_addr;
            len_q     <= length;
            first_q   <= pass_first;
            last_q    <= pass_last;
            acc_cnt   <= '0;
            iss_cnt   <= '0;
            wr_cnt    <= '0;
            err_sat_q <= 1'b0;
        end else if (state == RUN) begin
            if (push) begin
                acc_cnt <= acc_cnt + 1'b1;
            end
            if (grant) begin
                iss_cnt <= iss_cnt + 1'b1;
            end
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (|lane_sat) begin
                    err_sat_q <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy. The storage array has no reset because
    // emptying the FIFO only requires clearing the pointers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= in_data;
        end
    end

    // Each granted read travels down this chain and reaches the last stage
    // in the cycle its data is on rd_data. Reset drops reads in flight.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= grant;
            for (int i = 1; i < RdLatency; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    // Per-lane saturating add. Both operands are sign-extended by one bit.
    // Overflow shows up as a mismatch between the top two bits, and the top
    // bit then gives the direction of the clamp.
    always_comb begin
        sum_word = '0;
        lane_sat = '0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        lane_res = '0;
        for (int k = 0; k < NumCh; k++) begin
            lane_a   = head_word[k*DataWidth +: DataWidth];
            lane_b   = addend[k*DataWidth +: DataWidth];
            lane_sum = {lane_a[DataWidth-1], lane_a} + {lane_b[DataWidth-1], lane_b};
            if (lane_sum[DataWidth] != lane_sum[DataWidth-1]) begin
                lane_sat[k] = 1'b1;
                lane_res    = lane_sum[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                                  : {1'b0, {(DataWidth-1){1'b1}}};
            end else begin
                lane_res = lane_sum[DataWidth-1:0];
            end
`ifdef CONV_ACCUM_RELU_EN
            if (last_q && lane_res[DataWidth-1]) begin
                lane_res = '0;
            end
`endif
            sum_word[k*DataWidth +: DataWidth] = lane_res;
        end
    end

`ifndef CONV_ACCUM_RELU_EN
    // Without ReLU the latched pass_last flag has no consumer.
    logic unused_last;
    assign unused_last = last_q;
`endif

    // Registered write-back. The address is taken from the write counter
    // before it advances, so writes follow pass order from base_addr.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr <= base_q + wr_cnt;
                wr_data <= sum_word;
            end
        end
    end

endmodule

// File: tb/tb_conv_accum_stream.sv
// ---------------------------------------------------------------------------
// tb_conv_accum_stream
//
// Directed bench for conv_accum_stream using a scoreboard. Every accepted
// beat pushes its hand-computed expected write (address and data) into a
// queue. An independent monitor pops that queue whenever the DUT asserts
// wr_en and compares the values.
//
// A psum SRAM model returns the preloaded word at the granted address after
// RdLatency cycles. Otherwise it returns a garbage pattern, so wrong
// addresses or wrong timing corrupt the sums.
// ---------------------------------------------------------------------------
module tb_conv_accum_stream;

    localparam int DataWidth = 32;
    localparam int NumCh     = 4;
    localparam int AddrWidth = 16;
    localparam int RdLatency = 2;
    localparam int FifoDepth = 8;
    localparam int BeatW     = NumCh * DataWidth;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [BeatW-1:0]     data;
    } exp_t;

    logic                 Clk;
    logic                 Rst;
    logic                 start;
    logic [AddrWidth-1:0] base_addr;
    logic [AddrWidth-1:0] length;
    logic                 pass_first;
    logic                 pass_last;
    logic                 busy;
    logic                 done;
    logic                 err_sat;
    logic [BeatW-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 rd_en;
    logic                 rd_gnt;
    logic [AddrWidth-1:0] rd_addr;
    logic [BeatW-1:0]     rd_data;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [BeatW-1:0]     wr_data;

    exp_t sbQ[$];
    int   total       = 0;
    int   bad         = 0;
    int   cyc         = 0;
    int   rdSeen      = 0;
    int   wrCount     = 0;
    int   firstWrCyc  = -1;
    int   acceptCount = 0;
    int   lastAccCyc  = 0;

    logic [BeatW-1:0]     psumMem [0:65535];
    logic [RdLatency-1:0] rdV;
    logic [AddrWidth-1:0] rdA [RdLatency];

    conv_accum_stream #(
        .DataWidth (DataWidth),
        .NumCh     (NumCh),
        .AddrWidth (AddrWidth),
        .RdLatency (RdLatency),
        .FifoDepth (FifoDepth)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .pass_first (pass_first),
        .pass_last  (pass_last),
        .busy       (busy),
        .done       (done),
        .err_sat    (err_sat),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_en      (rd_en),
        .rd_gnt     (rd_gnt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // SRAM read pipeline: address and valid flag travel for RdLatency cycles
    always @(posedge Clk) begin
        if (!Rst) begin
            rdV <= '0;
        end else begin
            rdV[0] <= rd_en && rd_gnt;
            rdA[0] <= rd_addr;
            for (int i = 1; i < RdLatency; i++) begin
                rdV[i] <= rdV[i-1];
                rdA[i] <= rdA[i-1];
            end
        end
    end

    assign rd_data = rdV[RdLatency-1] ? psumMem[rdA[RdLatency-1]] : {NumCh{32'hBAD0BAD0}};

    function automatic logic [BeatW-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                               input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic checkOutput(input string name, input logic [BeatW-1:0] act,
                               input logic [BeatW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: checks every write against the oldest expectation
    always @(negedge Clk) begin
        exp_t e;
        if (rd_en) rdSeen++;
        if (Rst && wr_en) begin
            wrCount++;
            if (firstWrCyc < 0) firstWrCyc = cyc;
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got write to %0h with data %0h, expected none",
                         wr_addr, wr_data);
            end else begin
                e = sbQ.pop_front();
                checkOutput("wr_addr", {{(BeatW-AddrWidth){1'b0}}, wr_addr},
                            {{(BeatW-AddrWidth){1'b0}}, e.addr});
                checkOutput("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic preload(input logic [AddrWidth-1:0] base, input int n,
                           input logic [BeatW-1:0] word);
        logic [AddrWidth-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + AddrWidth'(i);
            psumMem[a] = word;
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge
    task automatic startPass(input logic [AddrWidth-1:0] base, input logic [AddrWidth-1:0] len,
                             input logic first, input logic last);
        @(negedge Clk);
        base_addr  = base;
        length     = len;
        pass_first = first;
        pass_last  = last;
        start      = 1'b1;
        @(negedge Clk);
        start      = 1'b0;
    endtask

    // Offers one beat (from a negedge), queues its expected write on accept
    task automatic applyStimulus(input logic [BeatW-1:0] d, input logic [AddrWidth-1:0] ea,
                                 input logic [BeatW-1:0] ed);
        int n;
        exp_t e;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", {{(BeatW-1){1'b0}}, in_ready}, 1);
            in_valid = 1'b0;
        end else begin
            lastAccCyc = cyc;
            acceptCount++;
            e.addr = ea;
            e.data = ed;
            sbQ.push_back(e);
            @(negedge Clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({name, "_done"}, {{(BeatW-1){1'b0}}, done}, 1);
        checkOutput({name, "_busy_low"}, {{(BeatW-1){1'b0}}, busy}, 0);
        checkOutput({name, "_all_written"}, sbQ.size(), 0);
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_busy"},     {{(BeatW-1){1'b0}}, busy}, 0);
        checkOutput({name, "_done"},     {{(BeatW-1){1'b0}}, done}, 0);
        checkOutput({name, "_err_sat"},  {{(BeatW-1){1'b0}}, err_sat}, 0);
        checkOutput({name, "_in_ready"}, {{(BeatW-1){1'b0}}, in_ready}, 0);
        checkOutput({name, "_rd_en"},    {{(BeatW-1){1'b0}}, rd_en}, 0);
        checkOutput({name, "_wr_en"},    {{(BeatW-1){1'b0}}, wr_en}, 0);
        checkOutput({name, "_rd_addr"},  {{(BeatW-AddrWidth){1'b0}}, rd_addr}, 0);
        checkOutput({name, "_wr_addr"},  {{(BeatW-AddrWidth){1'b0}}, wr_addr}, 0);
        checkOutput({name, "_wr_data"},  wr_data, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc0;
        int rdBefore;
        int wrBefore;
        logic [31:0] reluLane;

        Rst        = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        pass_first = 1'b0;
        pass_last  = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        rd_gnt     = 1'b0;
        repeat (3) @(negedge Clk);
        checkIdleOutputs("reset");
        Rst = 1'b1;

        $display("[TB] test 1: first pass, direct write");
        rdBefore   = rdSeen;
        firstWrCyc = -1;
        startPass(16'h0010, 16'd4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(lanes(1, 2, 3, 4), 16'h0010 + AddrWidth'(i), lanes(1, 2, 3, 4));
            if (i == 0) acc0 = lastAccCyc;
        end
        waitDone("t1");
        checkOutput("t1_no_read", rdSeen - rdBefore, 0);
        checkOutput("t1_latency", firstWrCyc - acc0, 2);
        checkOutput("t1_err_sat", {{(BeatW-1){1'b0}}, err_sat}, 0);

        $display("[TB] test 2: accumulate pass, uncontended grant");
        preload(16'h0020, 8, lanes(100, 100, 100, 100));
        rd_gnt     = 1'b1;
        firstWrCyc = -1;
        startPass(16'h0020, 16'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(lanes(32'hFFFFFFE2, 32'hFFFFFFE2, 32'hFFFFFFE2, 32'hFFFFFFE2),
                          16'h0020 + AddrWidth'(i), lanes(70, 70, 70, 70));
            if (i == 0) acc0 = lastAccCyc;
        end
        waitDone("t2");
        checkOutput("t2_latency", firstWrCyc - acc0, RdLatency + 2);
        checkOutput("t2_err_sat", {{(BeatW-1){1'b0}}, err_sat}, 0);

        $display("[TB] test 3: grant withheld, FIFO back-pressure");
        preload(16'h0040, 12, lanes(100, 100, 100, 100));
        rd_gnt      = 1'b0;
        acceptCount = 0;
        wrBefore    = wrCount;
        startPass(16'h0040, 16'd12, 1'b0, 1'b0);
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    applyStimulus(lanes(5, 6, 7, 8), 16'h0040 + AddrWidth'(i),
                                  lanes(105, 106, 107, 108));
                end
            end
            begin
                repeat (20) @(negedge Clk);
                checkOutput("t3_fifo_fill", acceptCount, FifoDepth);
                checkOutput("t3_in_ready_low", {{(BeatW-1){1'b0}}, in_ready}, 0);
                checkOutput("t3_no_write_yet", wrCount - wrBefore, 0);
                rd_gnt = 1'b1;
            end
        join
        waitDone("t3");
        checkOutput("t3_write_count", wrCount - wrBefore, 12);

        $display("[TB] test 4: saturation");
        preload(16'h0060, 2, lanes(32'h7FFFFFF0, 32'h80000010, 5, 0));
        startPass(16'h0060, 16'd2, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(lanes(32'h20, 32'hFFFFFFE0, 1, 0), 16'h0060 + AddrWidth'(i),
                          lanes(32'h7FFFFFFF, 32'h80000000, 6, 0));
        end
        waitDone("t4");
        checkOutput("t4_err_sat", {{(BeatW-1){1'b0}}, err_sat}, 1);

        $display("[TB] test 5: zero length and last pass");
        wrBefore = wrCount;
        rdBefore = rdSeen;
        startPass(16'h0090, 16'd0, 1'b0, 1'b0);
        waitDone("t5a");
        checkOutput("t5a_err_cleared", {{(BeatW-1){1'b0}}, err_sat}, 0);
        checkOutput("t5a_no_write", wrCount - wrBefore, 0);
        checkOutput("t5a_no_read", rdSeen - rdBefore, 0);

`ifdef CONV_ACCUM_RELU_EN
        reluLane = 32'h0;
`else
        reluLane = 32'hFFFFFFFC;
`endif
        preload(16'h0070, 2, lanes(5, 5, 5, 5));
        startPass(16'h0070, 16'd2, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(lanes(32'hFFFFFFF7, 32'hFFFFFFF7, 32'hFFFFFFF7, 32'hFFFFFFF7),
                          16'h0070 + AddrWidth'(i), lanes(reluLane, reluLane, reluLane, reluLane));
        end
        waitDone("t5b");
        checkOutput("t5b_err_sat", {{(BeatW-1){1'b0}}, err_sat}, 0);

        $display("[TB] test 6: address wrap and mid-pass reset");
        preload(16'hFFFE, 4, lanes(10, 10, 10, 10));
        startPass(16'hFFFE, 16'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(lanes(1, 1, 1, 1), 16'hFFFE + AddrWidth'(i), lanes(11, 11, 11, 11));
        end
        waitDone("t6");

        preload(16'h0080, 8, lanes(0, 0, 0, 0));
        startPass(16'h0080, 16'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(lanes(9, 9, 9, 9), 16'h0080 + AddrWidth'(i), lanes(9, 9, 9, 9));
        end
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        sbQ.delete();
        wrBefore = wrCount;
        checkIdleOutputs("mid_reset");
        @(negedge Clk);
        Rst = 1'b1;
        repeat (10) @(negedge Clk);
        checkOutput("mid_reset_no_write", wrCount - wrBefore, 0);
        checkOutput("mid_reset_idle_busy", {{(BeatW-1){1'b0}}, busy}, 0);

        startPass(16'h0005, 16'd1, 1'b1, 1'b0);
        applyStimulus(lanes(7, 8, 9, 10), 16'h0005, lanes(7, 8, 9, 10));
        waitDone("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
